// File: rtl/ds_pkg.sv
// Shared constants, FSM state type and command table
// for the DualShock poll sequencer.
package ds_pkg;

  localparam logic [7:0] DS_CMD_START  = 8'h01;
  localparam logic [7:0] DS_CMD_POLL   = 8'h42;
  localparam logic [7:0] DS_ACK_BYTE   = 8'h5A;
  localparam logic [7:0] DS_ID_DIGITAL = 8'h41;
  localparam logic [7:0] DS_ID_ANALOG  = 8'h73;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    DONE
  } ds_state_t;

  function automatic logic [7:0] ds_cmd(
    input logic [3:0] idx
  );
    case (idx)
      4'd0:    return DS_CMD_START;
      4'd1:    return DS_CMD_POLL;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ds_sck_timer.sv
// Half-period tick for ps_clk and free-running
// poll-period tick for the DualShock sequencer.
module ds_sck_timer #(
  parameter int HALF   = 50,
  parameter int PERIOD = 420_000
) (
  input  logic clk_p,
  input  logic resetn,
  input  logic clr,
  output logic half_tick,
  output logic poll_tick
);

  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [HW-1:0] half_cnt;
  logic [PW-1:0] poll_cnt;

  assign half_tick = (half_cnt == HW'(HALF - 1));
  assign poll_tick = (poll_cnt == PW'(PERIOD - 1));

  always_ff @(posedge clk_p or negedge resetn) begin
    if (!resetn) begin
      half_cnt <= '0;
      poll_cnt <= '0;
    end else begin
      if (clr || half_tick) half_cnt <= '0;
      else                  half_cnt <= half_cnt + HW'(1);
      if (poll_tick) poll_cnt <= '0;
      else           poll_cnt <= poll_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/ds_poll_sequencer.sv
// DualShock poll sequencer: SEL-framed 0x01/0x42 poll,
// response captured and published atomically at frame end.
module ds_poll_sequencer
  import ds_pkg::*;
#(
  parameter int CLK_HZ       = 25_200_000,
  parameter int SCK_HZ       = 250_000,
  parameter int POLL_HZ      = 60,
  parameter int NBYTES       = 9,
  parameter int SETUP_HALVES = 4,
  parameter int GAP_HALVES   = 2
) (
  input  logic        clk_p,
  input  logic        resetn,
  input  logic        poll_req,
  output logic        ps_clk,
  output logic        ps_sel,
  output logic        ps_mosi,
  input  logic        ps_miso,
  output logic [47:0] joy_rx,
  output logic [7:0]  pad_id,
  output logic        frame_ok,
  output logic        frame_done,
  output logic        busy
);

  localparam int HALF   = CLK_HZ / (2 * SCK_HZ);
  localparam int PERIOD = CLK_HZ / POLL_HZ;

  ds_state_t   state;
  logic        pending;
  logic        take;
  logic        half_tick;
  logic        poll_tick;
  logic        miso_m;
  logic        miso_s;
  logic [4:0]  tick_cnt;
  logic [3:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [6:0]  shift;
  logic [7:0]  cap [9];
  logic [7:0]  cmd;
  logic [47:0] joy_next;
  logic        ack;

  assign take    = (state == IDLE) && pending;
  assign busy    = (state != IDLE);
  assign bit_idx = tick_cnt[3:1];
  assign cmd     = ds_cmd(byte_idx);
  assign ack     = (cap[2] == DS_ACK_BYTE);

  ds_sck_timer #(
    .HALF   (HALF),
    .PERIOD (PERIOD)
  ) u_timer (
    .clk_p     (clk_p),
    .resetn    (resetn),
    .clr       (take),
    .half_tick (half_tick),
    .poll_tick (poll_tick)
  );

  // Bytes past the end of a short frame read as released buttons
  always_comb begin
    joy_next = '1;
    for (int i = 3; i < 9; i++) begin
      if (i < NBYTES) joy_next[(i-3)*8 +: 8] = cap[i];
    end
  end

  always_ff @(posedge clk_p or negedge resetn) begin
    if (!resetn) begin
      miso_m <= 1'b1;
      miso_s <= 1'b1;
    end else begin
      miso_m <= ps_miso;
      miso_s <= miso_m;
    end
  end

  always_ff @(posedge clk_p or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pending    <= 1'b0;
      tick_cnt   <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      cap        <= '{default: 8'h00};
      ps_clk     <= 1'b1;
      ps_sel     <= 1'b1;
      ps_mosi    <= 1'b1;
      joy_rx     <= '1;
      pad_id     <= '0;
      frame_ok   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pending    <= (pending && !take) || poll_req || poll_tick;
      unique case (state)
        IDLE: begin
          if (pending) begin
            state    <= SETUP;
            ps_sel   <= 1'b0;
            tick_cnt <= '0;
          end
        end
        SETUP: begin
          if (half_tick) begin
            if (tick_cnt == 5'(SETUP_HALVES - 1)) begin
              state    <= SHIFT;
              tick_cnt <= '0;
              byte_idx <= '0;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        SHIFT: begin
          if (half_tick) begin
            tick_cnt <= tick_cnt + 5'd1;
            if (!tick_cnt[0]) begin
              ps_clk  <= 1'b0;
              ps_mosi <= cmd[bit_idx];
            end else begin
              ps_clk <= 1'b1;
              if (bit_idx != 3'd7) begin
                shift[bit_idx] <= miso_s;
              end else begin
                cap[byte_idx] <= {miso_s, shift};
                tick_cnt      <= '0;
                if (byte_idx == 4'(NBYTES - 1)) state <= DONE;
                else                            state <= GAP;
              end
            end
          end
        end
        GAP: begin
          ps_clk  <= 1'b1;
          ps_mosi <= 1'b1;
          if (half_tick) begin
            if (tick_cnt == 5'(GAP_HALVES - 1)) begin
              state    <= SHIFT;
              tick_cnt <= '0;
              byte_idx <= byte_idx + 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          ps_sel     <= 1'b1;
          ps_mosi    <= 1'b1;
          pad_id     <= cap[1];
          frame_ok   <= ack;
          frame_done <= 1'b1;
          if (ack) joy_rx <= joy_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_poll_sequencer.sv
// Bench for ds_poll_sequencer: pad models on two builds
// (9-byte and 5-byte) checked against a frame-level model.
module tb_ds_poll_sequencer;

  localparam int CLK_HZ  = 20_000;
  localparam int SCK_HZ  = 2_500;
  localparam int POLL_HZ = 10;
  localparam int HALF    = CLK_HZ / (2 * SCK_HZ);
  localparam int PERIOD  = CLK_HZ / POLL_HZ;
  localparam int TXN9    = (4 + 16*9 + 2*8) * HALF + 1;
  localparam int TXN5    = (4 + 16*5 + 2*4) * HALF + 1;
  localparam logic [39:0] RESP5 = 40'hFF_F7_5A_41_FF;
  localparam logic [71:0] CMD9  = {56'h0, 8'h42, 8'h01};

  logic clk_p = 1'b0;
  logic resetn = 1'b0;
  logic poll_req = 1'b0;
  logic req5 = 1'b0;
  logic ps_miso = 1'b1;
  logic miso5 = 1'b1;
  logic ps_clk, ps_sel, ps_mosi;
  logic frame_ok, frame_done, busy;
  logic [47:0] joy_rx;
  logic [7:0]  pad_id;
  logic clk5, sel5, mosi5, ok5, done5, busy5;
  logic [47:0] joy5;
  logic [7:0]  pad5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int fd_cnt = 0;
  logic [71:0] resp = '1;
  logic [71:0] lat = '1;
  logic [71:0] mosi_seen = '0;
  int rises = 0;
  int sel_fall = 0;
  int sel_rise = 0;
  int sel_len = 0;
  logic psel_q = 1'b1;
  logic pclk_q = 1'b1;
  int rises5 = 0;
  int fall5 = 0;
  int len5 = 0;
  logic sel5_q = 1'b1;
  logic clk5_q = 1'b1;
  logic [47:0] exp_joy = '1;
  logic [7:0]  exp_pad = '0;
  logic        exp_ok = 1'b0;

  ds_poll_sequencer #(
    .CLK_HZ(CLK_HZ), .SCK_HZ(SCK_HZ), .POLL_HZ(POLL_HZ), .NBYTES(9)
  ) dut (
    .clk_p(clk_p), .resetn(resetn), .poll_req(poll_req),
    .ps_clk(ps_clk), .ps_sel(ps_sel), .ps_mosi(ps_mosi),
    .ps_miso(ps_miso), .joy_rx(joy_rx), .pad_id(pad_id),
    .frame_ok(frame_ok), .frame_done(frame_done), .busy(busy)
  );

  ds_poll_sequencer #(
    .CLK_HZ(CLK_HZ), .SCK_HZ(SCK_HZ), .POLL_HZ(POLL_HZ), .NBYTES(5)
  ) dut5 (
    .clk_p(clk_p), .resetn(resetn), .poll_req(req5),
    .ps_clk(clk5), .ps_sel(sel5), .ps_mosi(mosi5),
    .ps_miso(miso5), .joy_rx(joy5), .pad_id(pad5),
    .frame_ok(ok5), .frame_done(done5), .busy(busy5)
  );

  always #5 clk_p = ~clk_p;

  always @(posedge clk_p) cyc++;

  always @(negedge clk_p) if (frame_done === 1'b1) fd_cnt++;

  // Pad model: shifts resp out LSB first, records MOSI on rises
  always @(ps_sel or ps_clk) begin
    if (psel_q === 1'b1 && ps_sel === 1'b0) begin
      lat = resp;
      rises = 0;
      sel_fall = cyc;
      mosi_seen = '0;
    end
    if (psel_q === 1'b0 && ps_sel === 1'b1) begin
      sel_rise = cyc;
      sel_len = cyc - sel_fall;
    end
    if (pclk_q === 1'b1 && ps_clk === 1'b0 && ps_sel === 1'b0)
      if (rises < 72) ps_miso = lat[rises];
    if (pclk_q === 1'b0 && ps_clk === 1'b1 && ps_sel === 1'b0) begin
      if (rises < 72) mosi_seen[rises] = ps_mosi;
      rises++;
    end
    psel_q = ps_sel;
    pclk_q = ps_clk;
  end

  always @(sel5 or clk5) begin
    if (sel5_q === 1'b1 && sel5 === 1'b0) begin
      rises5 = 0;
      fall5 = cyc;
    end
    if (sel5_q === 1'b0 && sel5 === 1'b1) len5 = cyc - fall5;
    if (clk5_q === 1'b1 && clk5 === 1'b0 && sel5 === 1'b0)
      if (rises5 < 40) miso5 = RESP5[rises5];
    if (clk5_q === 1'b0 && clk5 === 1'b1 && sel5 === 1'b0) rises5++;
    sel5_q = sel5;
    clk5_q = clk5;
  end

  // Frame-level reference: what the consumer should see after each frame
  always @(posedge frame_done or negedge resetn) begin
    if (!resetn) begin
      exp_joy = '1;
      exp_pad = '0;
      exp_ok  = 1'b0;
    end else begin
      exp_pad = lat[15:8];
      exp_ok  = (lat[23:16] == 8'h5A);
      if (exp_ok) exp_joy = lat[71:24];
    end
  end

  task automatic pulse_req();
    @(negedge clk_p);
    poll_req = 1'b1;
    @(negedge clk_p);
    poll_req = 1'b0;
  endtask

  task automatic wait_fall(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_p);
      if (ps_sel === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_p);
      if (frame_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk_p);
    checks++;
    if ({ps_clk, ps_sel, ps_mosi} !== 3'b111) begin
      errors++;
      $display("FAIL reset_pins got=%b want=111", {ps_clk, ps_sel, ps_mosi});
    end
    checks++;
    if (joy_rx !== 48'hFFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_joy got=%h want=ffffffffffff", joy_rx);
    end
    checks++;
    if ({pad_id, frame_ok, frame_done, busy} !== 11'b0) begin
      errors++;
      $display("FAIL reset_status got=%h/%b%b%b want=00/000",
               pad_id, frame_ok, frame_done, busy);
    end
    checks++;
    if ({sel5, clk5, busy5} !== 3'b110 || joy5 !== 48'hFFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_dut5 got=%b%b%b %h want=110 all-ff",
               sel5, clk5, busy5, joy5);
    end
    resetn = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_periodic();
    bit got;
    int fd0;
    resp = {8'h80, 8'h80, 8'h80, 8'h80, 8'hFE, 8'h7F, 8'h5A, 8'h73, 8'hFF};
    wait_fall(2 * PERIOD, got);
    checks++;
    if (!got || sel_fall != c0 + PERIOD + 1) begin
      errors++;
      $display("FAIL first_poll_start got=%0d want=%0d", sel_fall - c0, PERIOD + 1);
    end
    fd0 = fd_cnt;
    wait_done(TXN9 + 20, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL periodic_done got=timeout want=frame_done");
    end
    checks++;
    if (sel_len != TXN9) begin
      errors++;
      $display("FAIL sel_low_len got=%0d want=%0d", sel_len, TXN9);
    end
    checks++;
    if (rises != 72) begin
      errors++;
      $display("FAIL clk_rises got=%0d want=72", rises);
    end
    checks++;
    if (mosi_seen !== CMD9) begin
      errors++;
      $display("FAIL mosi_stream got=%h want=%h", mosi_seen, CMD9);
    end
    checks++;
    if (pad_id !== 8'h73 || frame_ok !== 1'b1) begin
      errors++;
      $display("FAIL periodic_id got=%h/%b want=73/1", pad_id, frame_ok);
    end
    checks++;
    if (joy_rx !== 48'h8080_8080_FE7F || joy_rx !== exp_joy) begin
      errors++;
      $display("FAIL periodic_joy got=%h want=808080 80fe7f model=%h", joy_rx, exp_joy);
    end
    repeat (4) @(negedge clk_p);
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL frame_done_count got=%0d want=1", fd_cnt - fd0);
    end
  endtask

  task automatic test_bad_ack();
    bit got;
    resp[71:24] = {16'($urandom()), $urandom()};
    resp[23:0]  = 24'h00_41_FF;
    pulse_req();
    wait_done(TXN9 + 50, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bad_ack_done got=timeout want=frame_done");
    end
    checks++;
    if (frame_ok !== 1'b0 || pad_id !== 8'h41) begin
      errors++;
      $display("FAIL bad_ack_status got=%b/%h want=0/41", frame_ok, pad_id);
    end
    checks++;
    if (joy_rx !== 48'h8080_8080_FE7F || joy_rx !== exp_joy) begin
      errors++;
      $display("FAIL bad_ack_joy got=%h want=80808080fe7f", joy_rx);
    end
  endtask

  task automatic test_collapse();
    bit got;
    int fd0;
    wait_fall(2 * PERIOD, got);
    checks++;
    if (!got || sel_fall != c0 + 2 * PERIOD + 1) begin
      errors++;
      $display("FAIL second_poll_start got=%0d want=%0d",
               sel_fall - c0, 2 * PERIOD + 1);
    end
    fd0 = fd_cnt;
    resp = {48'h1234_5678_9ABC, 24'h5A_73_FF};
    repeat (3) begin
      repeat (40) @(negedge clk_p);
      pulse_req();
    end
    wait_done(TXN9, got);
    wait_fall(10, got);
    checks++;
    if (!got || sel_fall != sel_rise + 1) begin
      errors++;
      $display("FAIL collapse_restart got=%0d want=%0d", sel_fall - sel_rise, 1);
    end
    wait_done(TXN9 + 20, got);
    checks++;
    if (!got || joy_rx !== 48'h1234_5678_9ABC) begin
      errors++;
      $display("FAIL collapse_joy got=%h want=123456789abc", joy_rx);
    end
    wait_fall(2 * PERIOD, got);
    checks++;
    if (!got || sel_fall != c0 + 3 * PERIOD + 1) begin
      errors++;
      $display("FAIL after_collapse_start got=%0d want=%0d",
               sel_fall - c0, 3 * PERIOD + 1);
    end
    checks++;
    if (fd_cnt - fd0 != 2) begin
      errors++;
      $display("FAIL collapse_count got=%0d want=2", fd_cnt - fd0);
    end
    wait_done(TXN9 + 20, got);
  endtask

  task automatic test_random();
    bit got;
    for (int n = 0; n < 5; n++) begin
      resp[71:24] = {16'($urandom()), $urandom()};
      resp[15:8]  = ($urandom_range(0, 1) != 0) ? 8'h73 : 8'h41;
      resp[23:16] = ($urandom_range(0, 3) != 0) ? 8'h5A : 8'($urandom());
      resp[7:0]   = 8'hFF;
      pulse_req();
      wait_done(2 * TXN9 + 50, got);
      checks++;
      if (!got || pad_id !== exp_pad || frame_ok !== exp_ok) begin
        errors++;
        $display("FAIL rand_status[%0d] got=%h/%b want=%h/%b",
                 n, pad_id, frame_ok, exp_pad, exp_ok);
      end
      checks++;
      if (joy_rx !== exp_joy) begin
        errors++;
        $display("FAIL rand_joy[%0d] got=%h want=%h", n, joy_rx, exp_joy);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int fd0;
    pulse_req();
    got = 1'b0;
    for (int i = 0; i < 3 * TXN9; i++) begin
      @(negedge clk_p);
      if (ps_sel === 1'b0 && rises == 35) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reach_byte4 got=timeout want=rise35");
    end
    fd0 = fd_cnt;
    resetn = 1'b0;
    #1;
    checks++;
    if ({ps_sel, ps_clk, busy, frame_done} !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_pins got=%b want=1100",
               {ps_sel, ps_clk, busy, frame_done});
    end
    checks++;
    if (joy_rx !== 48'hFFFF_FFFF_FFFF || pad_id !== 8'h00) begin
      errors++;
      $display("FAIL midreset_out got=%h/%h want=all-ff/00", joy_rx, pad_id);
    end
    repeat (20) @(negedge clk_p);
    checks++;
    if (fd_cnt != fd0) begin
      errors++;
      $display("FAIL midreset_done got=%0d want=0", fd_cnt - fd0);
    end
    resetn = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_nbytes5();
    bit got;
    @(negedge clk_p);
    req5 = 1'b1;
    @(negedge clk_p);
    req5 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3 * TXN5; i++) begin
      @(negedge clk_p);
      if (done5 === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || pad5 !== 8'h41 || ok5 !== 1'b1) begin
      errors++;
      $display("FAIL nb5_status got=%h/%b want=41/1", pad5, ok5);
    end
    checks++;
    if (joy5 !== 48'hFFFF_FFFF_FFF7) begin
      errors++;
      $display("FAIL nb5_joy got=%h want=fffffffffff7", joy5);
    end
    checks++;
    if (rises5 != 40 || len5 != TXN5) begin
      errors++;
      $display("FAIL nb5_frame got=%0d/%0d want=40/%0d", rises5, len5, TXN5);
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_periodic();
    test_bad_ack();
    test_collapse();
    test_random();
    test_reset_mid();
    test_nbytes5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
